ps2_key_fifo: RTL

Parametrised PS/2 keyboard receiver and the successor to the single-register scan-code capture. It adds:
- glitch filtering on the PS/2 clock;
- full 11-bit frame checking with odd parity, start and stop bits;
- a frame watchdog;
- make/break/extended decoding into events;
- a FIFO of events with a valid/ready output.

It sits between the PS/2 pins and game-control logic, so no key event is lost between polls.

---
 rtl/ps2_key_fifo_if.sv | 18 +
 rtl/ps2_key_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo_if.sv
// ----------------------------------------------------------------------------
// ps2_key_fifo_if
// Valid/ready stream that carries decoded key events out of ps2_key_fifo.
//   evt_valid : FIFO holds at least one event; evt_data is meaningful
//   evt_ready : consumer accepts the head event this cycle
//   evt_data  : {brk, ext, code[7:0]} of the head event
// Modports:
//   master : event producer (the keyboard receiver)
//   slave  : event consumer (game-control logic)
// ----------------------------------------------------------------------------
interface ps2_key_fifo_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;

    modport master (output evt_valid, output evt_data, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface

// File: rtl/ps2_key_fifo.sv
// ----------------------------------------------------------------------------
// ps2_key_fifo
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 clock,
// checks full 11-bit frames (start, 8 data LSB first, odd parity, stop),
// aborts stalled frames with a watchdog, folds E0/F0 prefixes into
// {brk, ext, code} events and queues them in a circular FIFO.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   evt        event stream (ps2_key_fifo_if.master)
//   fifo_count number of queued events, 0..2**FIFO_AW
//   overflow   one-cycle pulse: event dropped, FIFO full
//   frame_err  one-cycle pulse: bad start/parity/stop or watchdog timeout
//
// Parameters: FILTER_LEN (1..15), TIMEOUT_CYCLES (>=2), FIFO_AW.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses repeated makes of
// a key that is still held (typematic auto-repeat).
// ----------------------------------------------------------------------------
module ps2_key_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_key_fifo_if.master        evt,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  overflow,
    output logic                  frame_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL = DEPTH[FIFO_AW:0];
    localparam logic [WD_W-1:0]    WD_ONE  = 1;
    // frame_err is registered, so the timeout is flagged one cycle early to
    // make the pulse appear exactly TIMEOUT_CYCLES after the last fall.
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]         FILT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic fall;

    state_t state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic par_q, par_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic byte_done_q, byte_done_d;
    logic [7:0] byte_q, byte_d;
    logic err_q, err_d;

    logic ext_q, ext_d, brk_q, brk_d;
    logic push_req, push, pop;
    logic [9:0] push_data;

    logic [9:0] mem_q [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic ovf_q, ovf_d;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q, last_make_d;
    logic held_q, held_d;
`endif

    // Level-filtered PS/2 clock and the frame-level strobe derived from it.
    assign fall = filt_prev_q & ~filt_q;

    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // A run of differing samples must reach FILTER_LEN before the level flips.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
        filt_prev_d = filt_q;

        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        wd_d        = wd_q;
        byte_done_d = 1'b0;
        byte_d      = byte_q;
        err_d       = 1'b0;

        if (fall) begin
            wd_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_done_d = 1'b1;
                        byte_d      = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_IDLE) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            wd_d    = '0;
        end else begin
            wd_d = wd_q + WD_ONE;
        end

        // Prefix decoding: E0/F0 only arm flags, 00/FF are keyboard noise.
        ext_d     = ext_q;
        brk_d     = brk_q;
        push_req  = 1'b0;
        push_data = {brk_q, ext_q, byte_q};
        if (byte_done_q) begin
            case (byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    push_req = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            endcase
        end
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

`ifdef PS2_TYPEMATIC_FILTER_EN
        last_make_d = last_make_q;
        held_d      = held_q;
        if (push_req) begin
            if (!brk_q) begin
                if (held_q && (last_make_q == {ext_q, byte_q})) push_req = 1'b0;
                last_make_d = {ext_q, byte_q};
                held_d      = 1'b1;
            end else if (last_make_q == {ext_q, byte_q}) begin
                held_d = 1'b0;
            end
        end
`endif

        // A pop frees a slot in the same cycle, so push-at-full with pop succeeds.
        pop   = (count_q != '0) && evt.evt_ready;
        push  = push_req && ((count_q != CNT_FULL) || pop);
        ovf_d = push_req && (count_q == CNT_FULL) && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wd_q        <= '0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            err_q       <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_make_q <= '0;
            held_q      <= 1'b0;
`endif
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            byte_done_q <= byte_done_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_make_q <= last_make_d;
            held_q      <= held_d;
`endif
        end
    end

    // Storage array is not reset; stale entries are hidden by evt_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;
    assign frame_err     = err_q;
endmodule
